// File: rtl/conv_tile_sched_pkg.sv
// Shared definitions for the conv tile scheduler: default widths, PE op codes and the
// 4-bit CS_* state encoding that the decoder debug port and the bench both observe.
package conv_tile_sched_pkg;

  localparam int CS_DIM_W = 11;
  localparam int CS_EXT_W = 8;
  localparam int CS_K_W   = 5;

  typedef enum logic [1:0] {
    OP_LW  = 2'd0,
    OP_LIF = 2'd1,
    OP_SOF = 2'd2,
    OP_NOP = 2'd3
  } pe_op_e;

  typedef enum logic [3:0] {
    CS_IDLE = 4'd0,
    CS_LW   = 4'd1,
    CS_WLW  = 4'd2,
    CS_LIF  = 4'd3,
    CS_WLIF = 4'd4,
    CS_SOF  = 4'd5,
    CS_WSOF = 4'd6,
    CS_NEXT = 4'd7,
    CS_FIN  = 4'd8
  } cs_state_e;

endpackage

// File: rtl/conv_tile_sched_tile_axis_cnt.sv
// tile_axis_cnt: one tiling axis (origin register, step by tile size, wrap detect, clipped extent).
module tile_axis_cnt
  import conv_tile_sched_pkg::*;
#(
  parameter int ORI_W = CS_EXT_W,
  parameter int LIM_W = CS_DIM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [ORI_W-1:0] ext,
  input  logic [LIM_W-1:0] limit,
  output logic [ORI_W-1:0] ori,
  output logic [ORI_W-1:0] ext_clip,
  output logic             wrap
);

  localparam int CMP_W = LIM_W + 1;

  logic [ORI_W-1:0] ori_q, ori_d;
  logic [CMP_W-1:0] ext_w, next_w, rem_w, lim_w;

  // One extra bit so origin+extent can never wrap around the limit compare.
  always_comb begin
    ext_w    = CMP_W'(ext);
    lim_w    = CMP_W'(limit);
    next_w   = CMP_W'(ori_q) + ext_w;
    rem_w    = lim_w - CMP_W'(ori_q);
    wrap     = (next_w >= lim_w);
    ext_clip = (ext_w < rem_w) ? ext : rem_w[ORI_W-1:0];
    ori_d    = ori_q;
    if (clr) begin
      ori_d = '0;
    end else if (step) begin
      ori_d = next_w[ORI_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ori_q <= '0;
    end else begin
      ori_q <= ori_d;
    end
  end

  assign ori = ori_q;

endmodule

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks one conv layer over the PE as O/H/W output tiles, issuing LW/LIF/SOF pulses.
// Define CV_SCHED_PERF_EN to add the perf_cycles/perf_stall busy and wait-state counters.
module conv_tile_sched
  import conv_tile_sched_pkg::*;
#(
  parameter int DIM_W = CS_DIM_W,
  parameter int EXT_W = CS_EXT_W,
  parameter int K_W   = CS_K_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_O,
  input  logic [K_W-1:0]   cfg_K,
  input  logic [DIM_W-1:0] cfg_H,
  input  logic [DIM_W-1:0] cfg_W,
  input  logic [DIM_W-1:0] cfg_Oext,
  input  logic [EXT_W-1:0] cfg_Hext,
  input  logic [EXT_W-1:0] cfg_Wext,
  input  logic             pe_done,
  output logic             lw_start,
  output logic             lif_start,
  output logic             sof_start,
  output logic [DIM_W-1:0] t_Oori,
  output logic [EXT_W-1:0] t_Hori,
  output logic [EXT_W-1:0] t_Wori,
  output logic [DIM_W-1:0] t_Oext,
  output logic [EXT_W-1:0] t_Hext,
  output logic [EXT_W-1:0] t_Wext,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef CV_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall
`endif
);

  cs_state_e        state_q, state_d;
  logic             lw_start_q, lw_start_d, lif_start_q, lif_start_d;
  logic             sof_start_q, sof_start_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DIM_W-1:0] o_q, o_d, oext_q, oext_d, hout_q, hout_d, wout_q, wout_d;
  logic [EXT_W-1:0] hext_q, hext_d, wext_q, wext_d;
  logic [DIM_W-1:0] k_ext;
  logic             cfg_bad, accept;
  logic             o_clr, o_step, o_wrap, h_clr, h_step, h_wrap, w_clr, w_step, w_wrap;

  assign k_ext   = DIM_W'(cfg_K);
  assign cfg_bad = (cfg_K == '0) || (k_ext > cfg_H) || (k_ext > cfg_W) || (cfg_O == '0) ||
                   (cfg_Oext == '0) || (cfg_Hext == '0) || (cfg_Wext == '0);
  assign accept  = (state_q == CS_IDLE) && start && !abort;

  // NEXT advances W first, then H, then O; each wrap clears the inner axis.
  always_comb begin
    state_d     = state_q;
    lw_start_d  = 1'b0;
    lif_start_d = 1'b0;
    sof_start_d = 1'b0;
    done_d      = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    o_d         = o_q;
    oext_d      = oext_q;
    hout_d      = hout_q;
    wout_d      = wout_q;
    hext_d      = hext_q;
    wext_d      = wext_q;
    {o_clr, o_step, h_clr, h_step, w_clr, w_step} = '0;
    if (abort) begin
      state_d = CS_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        CS_IDLE: if (start) begin
          o_d    = cfg_O;
          oext_d = cfg_Oext;
          hext_d = cfg_Hext;
          wext_d = cfg_Wext;
          hout_d = cfg_H - k_ext + DIM_W'(1);
          wout_d = cfg_W - k_ext + DIM_W'(1);
          busy_d = 1'b1;
          err_d  = cfg_bad;
          if (cfg_bad) begin
            done_d  = 1'b1;
            state_d = CS_FIN;
          end else begin
            {o_clr, h_clr, w_clr} = 3'b111;
            lw_start_d = 1'b1;
            state_d    = CS_LW;
          end
        end
        CS_LW:   state_d = CS_WLW;
        CS_WLW:  if (pe_done) begin
          lif_start_d = 1'b1;
          state_d     = CS_LIF;
        end
        CS_LIF:  state_d = CS_WLIF;
        CS_WLIF: if (pe_done) begin
          sof_start_d = 1'b1;
          state_d     = CS_SOF;
        end
        CS_SOF:  state_d = CS_WSOF;
        CS_WSOF: if (pe_done) state_d = CS_NEXT;
        CS_NEXT: begin
          if (!w_wrap) begin
            w_step      = 1'b1;
            lif_start_d = 1'b1;
            state_d     = CS_LIF;
          end else begin
            w_clr = 1'b1;
            if (!h_wrap) begin
              h_step      = 1'b1;
              lif_start_d = 1'b1;
              state_d     = CS_LIF;
            end else begin
              h_clr  = 1'b1;
              o_step = 1'b1;
              if (!o_wrap) begin
                lw_start_d = 1'b1;
                state_d    = CS_LW;
              end else begin
                done_d  = 1'b1;
                state_d = CS_FIN;
              end
            end
          end
        end
        CS_FIN: begin
          busy_d  = 1'b0;
          state_d = CS_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = CS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CS_IDLE;
      lw_start_q  <= 1'b0;
      lif_start_q <= 1'b0;
      sof_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      o_q         <= '0;
      oext_q      <= '0;
      hout_q      <= '0;
      wout_q      <= '0;
      hext_q      <= '0;
      wext_q      <= '0;
    end else begin
      state_q     <= state_d;
      lw_start_q  <= lw_start_d;
      lif_start_q <= lif_start_d;
      sof_start_q <= sof_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      o_q         <= o_d;
      oext_q      <= oext_d;
      hout_q      <= hout_d;
      wout_q      <= wout_d;
      hext_q      <= hext_d;
      wext_q      <= wext_d;
    end
  end

  tile_axis_cnt #(.ORI_W(DIM_W), .LIM_W(DIM_W)) u_o_axis (
    .clk(clk), .rst_n(rst_n), .clr(o_clr), .step(o_step), .ext(oext_q), .limit(o_q),
    .ori(t_Oori), .ext_clip(t_Oext), .wrap(o_wrap)
  );

  tile_axis_cnt #(.ORI_W(EXT_W), .LIM_W(DIM_W)) u_h_axis (
    .clk(clk), .rst_n(rst_n), .clr(h_clr), .step(h_step), .ext(hext_q), .limit(hout_q),
    .ori(t_Hori), .ext_clip(t_Hext), .wrap(h_wrap)
  );

  tile_axis_cnt #(.ORI_W(EXT_W), .LIM_W(DIM_W)) u_w_axis (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .step(w_step), .ext(wext_q), .limit(wout_q),
    .ori(t_Wori), .ext_clip(t_Wext), .wrap(w_wrap)
  );

  assign lw_start  = lw_start_q;
  assign lif_start = lif_start_q;
  assign sof_start = sof_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef CV_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stall_q, perf_stall_d;
  logic        in_wait;

  // Both counters saturate and simply hold once busy drops after done.
  always_comb begin
    in_wait       = (state_q == CS_WLW) || (state_q == CS_WLIF) || (state_q == CS_WSOF);
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (accept) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy_q && !(&perf_cycles_q)) perf_cycles_d = perf_cycles_q + 32'd1;
      if (in_wait && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Scoreboard bench for conv_tile_sched: a loop-nest layer model fills an event queue,
// a monitor pops and compares on every pulse, and a PE responder returns pe_done.
module tb_conv_tile_sched;
  import conv_tile_sched_pkg::*;

  localparam int DIM_W = 11;
  localparam int EXT_W = 8;
  localparam int K_W   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pe_done = 1'b0;
  logic [DIM_W-1:0] cfg_O = '0, cfg_H = '0, cfg_W = '0, cfg_Oext = '0;
  logic [K_W-1:0]   cfg_K = '0;
  logic [EXT_W-1:0] cfg_Hext = '0, cfg_Wext = '0;
  logic             lw_start, lif_start, sof_start, busy, done, err;
  logic [DIM_W-1:0] t_Oori, t_Oext;
  logic [EXT_W-1:0] t_Hori, t_Wori, t_Hext, t_Wext;

  conv_tile_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_O(cfg_O), .cfg_K(cfg_K), .cfg_H(cfg_H), .cfg_W(cfg_W),
    .cfg_Oext(cfg_Oext), .cfg_Hext(cfg_Hext), .cfg_Wext(cfg_Wext),
    .pe_done(pe_done), .lw_start(lw_start), .lif_start(lif_start), .sof_start(sof_start),
    .t_Oori(t_Oori), .t_Hori(t_Hori), .t_Wori(t_Wori),
    .t_Oext(t_Oext), .t_Hext(t_Hext), .t_Wext(t_Wext),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 LW, 1 LIF, 2 SOF, 3 DONE
  typedef struct {
    int kind;
    int oori, hori, wori, oext, hext, wext;
    bit err;
    bit first;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  lw_seen = 0, lif_seen = 0, sof_seen = 0, done_seen = 0;
  int  acks_given = 0, ack_mark = 0;
  int  rsp_pending = 0, rsp_wait = 0;
  bit  spur_en = 1'b0, idle_poke = 1'b0;
  int  mon_n, mon_kind;
  ev_t mon_e;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [63:0] outvec();
    return 64'({lw_start, lif_start, sof_start, busy, done, err,
                t_Oori, t_Hori, t_Wori, t_Oext, t_Hext, t_Wext});
  endfunction

  // Reference layer: O tiles outer, H tiles, W tiles inner, each extent clipped at the edge.
  task automatic pushModel(input int o, k, h, w, oe, he, we);
    ev_t e;
    int  hout, wout;
    if (k == 0 || k > h || k > w || o == 0 || oe == 0 || he == 0 || we == 0) begin
      e = '{3, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0};
      exp_q.push_back(e);
      return;
    end
    hout = h - k + 1;
    wout = w - k + 1;
    for (int oo = 0; oo < o; oo += oe) begin
      e = '{0, oo, 0, 0, imin(oe, o - oo), imin(he, hout), imin(we, wout), 1'b0, oo == 0};
      exp_q.push_back(e);
      for (int hh = 0; hh < hout; hh += he) begin
        for (int ww = 0; ww < wout; ww += we) begin
          e = '{1, oo, hh, ww, imin(oe, o - oo), imin(he, hout - hh), imin(we, wout - ww), 1'b0, 1'b0};
          exp_q.push_back(e);
          e.kind = 2;
          exp_q.push_back(e);
        end
      end
    end
    e = '{3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int o, k, h, w, oe, he, we);
    @(negedge clk);
    cfg_O = DIM_W'(o);  cfg_K = K_W'(k);  cfg_H = DIM_W'(h);  cfg_W = DIM_W'(w);
    cfg_Oext = DIM_W'(oe);  cfg_Hext = EXT_W'(he);  cfg_Wext = EXT_W'(we);
    pushModel(o, k, h, w, oe, he, we);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_O = DIM_W'($urandom);  cfg_K = K_W'($urandom);  cfg_H = DIM_W'($urandom);
    cfg_W = DIM_W'($urandom);  cfg_Oext = DIM_W'($urandom);
    cfg_Hext = EXT_W'($urandom);  cfg_Wext = EXT_W'($urandom);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_reached", done_seen >= target, 1);
    if (done_seen < target) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    @(negedge clk);
    #1;
    checkOutput("busy_after_done", busy, 0);
    checkOutput("done_once", done_seen, target);
    checkOutput("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // PE model: may pulse pe_done spuriously in the *_start cycle, then acks after 1..3 cycles.
  always @(negedge clk) begin
    pe_done = 1'b0;
    if (!rst_n) begin
      rsp_pending = 0;
    end else if (lw_start || lif_start || sof_start) begin
      if (spur_en && $urandom_range(0, 1) == 1) pe_done = 1'b1;
      rsp_wait    = $urandom_range(1, 3);
      rsp_pending = 1;
    end else if (rsp_pending != 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        pe_done     = 1'b1;
        rsp_pending = 0;
        acks_given++;
      end
    end else if (idle_poke) begin
      pe_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = int'(lw_start) + int'(lif_start) + int'(sof_start) + int'(done);
      if (mon_n > 1) begin
        checkOutput("single_pulse", mon_n, 1);
      end else if (mon_n == 1) begin
        mon_kind = lw_start ? 0 : lif_start ? 1 : sof_start ? 2 : 3;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_event", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("event_kind", mon_kind, mon_e.kind);
          checkOutput("event_busy", busy, 1);
          checkOutput("event_err", err, mon_e.err);
          if (mon_kind != 3 && mon_kind == mon_e.kind) begin
            checkOutput("t_Oori", t_Oori, mon_e.oori);
            checkOutput("t_Hori", t_Hori, mon_e.hori);
            checkOutput("t_Wori", t_Wori, mon_e.wori);
            checkOutput("t_Oext", t_Oext, mon_e.oext);
            checkOutput("t_Hext", t_Hext, mon_e.hext);
            checkOutput("t_Wext", t_Wext, mon_e.wext);
            if (!mon_e.first) checkOutput("pe_handshake", acks_given - ack_mark, 1);
            ack_mark = acks_given;
          end
        end
        case (mon_kind)
          0: lw_seen++;
          1: lif_seen++;
          2: sof_seen++;
          default: done_seen++;
        endcase
      end
    end
  end

  initial begin
    int lw0, lif0, sof0, tgt, n, seen;
    int o, k, h, w, oe, he, we;
    #1;
    checkOutput("reset_outputs", outvec(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    idle_poke = 1'b1;
    repeat (3) @(negedge clk);
    idle_poke = 1'b0;
    #1;
    checkOutput("idle_poke_busy", busy, 0);

    lw0 = lw_seen;  lif0 = lif_seen;  sof0 = sof_seen;  tgt = done_seen + 1;
    applyStimulus(8, 3, 6, 6, 4, 2, 2);
    waitDone(tgt, 2000);
    checkOutput("layer1_lw_count", lw_seen - lw0, 2);
    checkOutput("layer1_lif_count", lif_seen - lif0, 8);
    checkOutput("layer1_sof_count", sof_seen - sof0, 8);

    tgt = done_seen + 1;
    applyStimulus(1, 3, 7, 4, 1, 2, 2);
    waitDone(tgt, 2000);

    spur_en = 1'b1;
    lw0 = lw_seen + lif_seen + sof_seen;  tgt = done_seen + 1;
    applyStimulus(1, 4, 3, 3, 1, 1, 1);
    #1;
    checkOutput("illegal_done_next_cycle", done, 1);
    checkOutput("illegal_err", err, 1);
    waitDone(tgt, 20);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", err, 1);
    checkOutput("illegal_no_pulses", lw_seen + lif_seen + sof_seen - lw0, 0);

    tgt = done_seen + 1;
    applyStimulus(8, 3, 6, 6, 4, 2, 2);
    #1;
    checkOutput("err_cleared_by_start", err, 0);
    n = 0;  seen = 0;
    while (seen < 2 && n < 3000) begin
      @(posedge clk);
      #1;
      if (sof_start) seen++;
      n++;
    end
    checkOutput("abort_reached_sof2", seen, 2);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_pulses", {lw_start, lif_start, sof_start, done}, 0);
    exp_q.delete();
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", done_seen, tgt - 1);
    checkOutput("abort_err_unchanged", err, 0);

    tgt = done_seen + 1;
    applyStimulus(8, 3, 6, 6, 4, 2, 2);
    n = 0;
    while (lif_seen == lif0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    cfg_O = DIM_W'(3);  cfg_K = K_W'(1);  cfg_H = DIM_W'(2);  cfg_W = DIM_W'(2);
    cfg_Oext = DIM_W'(1);  cfg_Hext = EXT_W'(1);  cfg_Wext = EXT_W'(1);
    @(negedge clk);
    start = 1'b0;
    waitDone(tgt, 3000);

    applyStimulus(4, 2, 5, 5, 2, 2, 2);
    checkOutput("rst_precond_lw", lw_start, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_in_wlw_outputs", outvec(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      k  = $urandom_range(1, 3);
      h  = k + $urandom_range(0, 4);
      w  = k + $urandom_range(0, 4);
      o  = $urandom_range(1, 4);
      oe = $urandom_range(1, 4);
      he = $urandom_range(1, 4);
      we = $urandom_range(1, 4);
      case ($urandom_range(0, 7))
        0: oe = 0;
        1: k = h + 1;
        2: we = 0;
        default: ;
      endcase
      tgt = done_seen + 1;
      applyStimulus(o, k, h, w, oe, he, we);
      waitDone(tgt, 5000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
